pulse_demod_mc: RTL

PULSE_DEMOD_MC -- requirements
Module: pulse_demod_mc

---
 rtl/pulse_demod_pkg.sv | 13 +
 rtl/pulse_demod_chan.sv | 106 ++++++++++
 rtl/pulse_demod_mc.sv | 40 ++++
 3 files changed

// File: rtl/pulse_demod_pkg.sv
// Shared definitions for the multi-channel pulse demodulator: channel FSM
// state encodings and the default counter width.
package pulse_demod_pkg;

   localparam int DEF_CTR_W = 16;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_COUNT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_demod_chan.sv
// One demodulator channel: WAIT -> COUNT (pulse) -> optional HOLD (dead time).
// Define PULSE_DEMOD_EDGE_DETECT_EN for rising-edge triggers; default is level triggers.
module pulse_demod_chan
   import pulse_demod_pkg::*;
#(
   parameter int CTR_W = DEF_CTR_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in,
   input  logic [CTR_W-1:0] i_pw,
   input  logic [CTR_W-1:0] i_hold,
   input  logic             i_retrig,
   input  logic             i_clr,
   output logic             o_out,
   output logic             o_ovr,
   output logic             o_busy
);

   state_t           r_state, w_state_nx;
   logic [CTR_W-1:0] r_cnt, w_cnt_nx;
   logic [CTR_W-1:0] r_width, w_width_nx;
   logic [CTR_W-1:0] r_hold, w_hold_nx;
   logic             r_ovr, w_ovr_set;
   logic             w_trig, w_pw_nz, w_cnt_end, w_hold_end;

`ifdef PULSE_DEMOD_EDGE_DETECT_EN
   // History starts high so an input held high across reset is not an edge.
   logic r_prev;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_prev <= 1'b1;
      else          r_prev <= i_in;
   end
   assign w_trig = i_in & ~r_prev;
`else
   assign w_trig = i_in;
`endif

   assign w_pw_nz    = |i_pw;
   assign w_cnt_end  = (r_cnt == r_width - CTR_W'(1));
   assign w_hold_end = (r_cnt == r_hold - CTR_W'(1));

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_width_nx = r_width;
      w_hold_nx  = r_hold;
      w_ovr_set  = 1'b0;
      unique case (r_state)
         ST_WAIT: begin
            if (w_trig && w_pw_nz) begin
               w_state_nx = ST_COUNT;
               w_cnt_nx   = '0;
               w_width_nx = i_pw;
               w_hold_nx  = i_hold;
            end
         end
         ST_COUNT: begin
            // A retrigger that would latch a zero width cannot restart; it is lost.
            if (w_trig && i_retrig && w_pw_nz) begin
               w_cnt_nx   = '0;
               w_width_nx = i_pw;
            end else begin
               w_ovr_set = w_trig;
               if (w_cnt_end) begin
                  w_cnt_nx   = '0;
                  w_state_nx = (r_hold == '0) ? ST_WAIT : ST_HOLD;
               end else begin
                  w_cnt_nx = r_cnt + CTR_W'(1);
               end
            end
         end
         ST_HOLD: begin
            w_ovr_set = w_trig;
            if (w_hold_end) begin
               w_cnt_nx   = '0;
               w_state_nx = ST_WAIT;
            end else begin
               w_cnt_nx = r_cnt + CTR_W'(1);
            end
         end
         default: w_state_nx = ST_WAIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_WAIT;
         r_cnt   <= '0;
         r_width <= '0;
         r_hold  <= '0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_width <= w_width_nx;
         r_hold  <= w_hold_nx;
         r_ovr   <= w_ovr_set | (r_ovr & ~i_clr);
      end
   end

   assign o_out  = (r_state == ST_COUNT);
   assign o_busy = (r_state != ST_WAIT);
   assign o_ovr  = r_ovr;

endmodule

// File: rtl/pulse_demod_mc.sv
// Multi-channel pulse demodulator top: CHANNELS independent channels sharing
// width/holdoff settings. Trigger mode selected by PULSE_DEMOD_EDGE_DETECT_EN.
module pulse_demod_mc
   import pulse_demod_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CTR_W    = DEF_CTR_W
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic [CHANNELS-1:0] in,
   input  logic [CTR_W-1:0]    pulse_width,
   input  logic [CTR_W-1:0]    holdoff,
   input  logic                retrig_en,
   input  logic [CHANNELS-1:0] overrun_clr,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] overrun,
   output logic                busy
);

   logic [CHANNELS-1:0] w_busy;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      pulse_demod_chan #(.CTR_W(CTR_W)) u_chan (
         .i_clk    (clk),
         .i_rst_n  (n_reset),
         .i_in     (in[g]),
         .i_pw     (pulse_width),
         .i_hold   (holdoff),
         .i_retrig (retrig_en),
         .i_clr    (overrun_clr[g]),
         .o_out    (out[g]),
         .o_ovr    (overrun[g]),
         .o_busy   (w_busy[g])
      );
   end

   assign busy = |w_busy;

endmodule
